ysyx_23060278_mdu: RTL and testbench
====================================

YSYX_23060278_MDU -- requirements
Module: ysyx_23060278_mdu

Interface
REQ-001 SHALL have no parameters; all datapaths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  issuing stage presents an operation.
REQ-005 in_ready  output  1  MDU can accept an operation.
REQ-006 op  input  3  RV32M funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-007 a  input  32  rs1 operand (multiplicand or dividend).
REQ-008 b  input  32  rs2 operand (multiplier or divisor).
REQ-009 kill  input  1  flushes any in-flight operation.
REQ-010 out_valid  output  1  result is available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 result  output  32  operation result.
REQ-013 zf  output  1  result == 0.
REQ-014 nf  output  1  result[31].

Function
REQ-015 SHALL implement three states: IDLE, BUSY and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 out_valid SHALL be 1 only in DONE.
REQ-018 Acceptance SHALL occur on an edge with in_valid & in_ready & ~kill; at that edge op, a and b are latched.
REQ-019 Accepted normal ops SHALL transition IDLE->BUSY.
REQ-020 A 6-bit counter SHALL count 32 iteration edges in BUSY, then the state SHALL go to DONE.
REQ-021 out_valid SHALL rise on the 33rd edge after acceptance.
REQ-022 Multiply SHALL use a radix-2 shift-add over a 64-bit product; one multiplier bit per edge.
REQ-023 Operand sign handling SHALL be: mul/mulh both operands signed; mulhsu a signed, b unsigned; mulhu both unsigned.
REQ-024 mul SHALL return product[31:0]; mulh/mulhsu/mulhu SHALL return product[63:32].
REQ-025 Divide SHALL use restoring division on magnitudes; one quotient bit per edge.
REQ-026 For signed div, the quotient SHALL be negated when the operand signs differ.
REQ-027 For signed rem, the remainder SHALL take the dividend's sign.
REQ-028 Divide by zero (b==0, ops 1xx) SHALL go IDLE->DONE in 1 edge with quotient 0xFFFFFFFF and remainder = a.
REQ-029 Signed overflow (a==0x80000000, b==0xFFFFFFFF, div/rem) SHALL go IDLE->DONE in 1 edge with quotient 0x80000000 and remainder 0.
REQ-030 In DONE, result, zf and nf SHALL stay stable until out_valid & out_ready.
REQ-031 On that out_valid & out_ready edge the state SHALL return to IDLE; no new accept occurs on the same edge.
REQ-032 kill SHALL have priority over all other events: from any state, next state IDLE, counter cleared, no out_valid.
REQ-033 kill in IDLE with in_valid SHALL block acceptance.
REQ-034 in_valid in BUSY or DONE SHALL be ignored; the operands of an operation in progress are unaffected.
REQ-035 result SHALL read 0 outside DONE.
REQ-036 zf and nf SHALL be derived combinationally from result.

Reset
REQ-037 Assertion of rst_n=0 SHALL immediately force IDLE, counter 0, internal product/remainder/quotient registers 0, result 0, out_valid 0 and in_ready 1, regardless of the clock.
REQ-038 Reset mid-BUSY or in DONE SHALL discard the operation with no output.
REQ-039 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-040 mul a=7, b=0xFFFFFFFD -> out_valid exactly 33 edges after accept, result 0xFFFFFFEB, nf=1, zf=0; mulhu with the same operands -> 0x00000006.
REQ-041 mulh a=b=0x80000000 -> 0x40000000; mulhsu a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-042 div a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; rem with the same operands -> 0xFFFFFFFF; remu a=100, b=7 -> 2; each after 33 edges.
REQ-043 divu a=0x1234, b=0 -> 0xFFFFFFFF after 1 edge; rem a=0x1234, b=0 -> 0x1234; div a=0x80000000, b=0xFFFFFFFF -> 0x80000000 after 1 edge; rem with those operands -> 0 with zf=1.
REQ-044 Backpressure: out_ready held 0 for 5 cycles in DONE -> result constant, in_ready 0, a changed in_valid ignored; out_ready=1 -> IDLE on the next edge.
REQ-045 kill at BUSY edge 10 -> IDLE next edge, out_valid never asserted; rst_n pulsed low mid-BUSY -> immediate IDLE; a following mul 3*5 -> 15.

Source files
------------

// File: rtl/ysyx_23060278_mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// division, one bit per clock, with an IDLE/BUSY/DONE handshake and a kill flush.
module ysyx_23060278_mdu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        kill,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zf,
  output logic        nf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] opnd_q, opnd_d;
  logic [31:0] mplr_q, mplr_d;
  logic [31:0] res_q, res_d;

  logic        accept, div0, ovf, d_sgn, last;
  logic [31:0] a_mag, b_mag;
  logic [63:0] addend, mul_acc, div_acc, step_acc;
  logic [32:0] shifted, trial;
  logic [31:0] fin_sel, fin_res;

  assign accept = in_valid && (state_q == IDLE) && !kill;
  assign d_sgn  = !op[0];
  assign a_mag  = (d_sgn && a[31]) ? -a : a;
  assign b_mag  = (d_sgn && b[31]) ? -b : b;
  assign div0   = op[2] && (b == 32'd0);
  assign ovf    = op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign last   = (cnt_q == 6'd31);

  // Multiply step: the top bit of a signed multiplier carries negative weight.
  assign addend  = mplr_q[0] ? ((last && neg_q) ? -opnd_q : opnd_q) : 64'd0;
  assign mul_acc = acc_q + addend;

  // Restoring divide step: acc holds {remainder, dividend/quotient}.
  assign shifted = {acc_q[63:32], acc_q[31]};
  assign trial   = shifted - {1'b0, opnd_q[31:0]};
  assign div_acc = trial[32] ? {shifted[31:0], acc_q[30:0], 1'b0}
                             : {trial[31:0], acc_q[30:0], 1'b1};

  assign step_acc = op_q[2] ? div_acc : mul_acc;

  always_comb begin
    fin_sel = step_acc[63:32];
    fin_res = fin_sel;
    if (op_q[2]) begin
      fin_sel = op_q[1] ? step_acc[63:32] : step_acc[31:0];
      fin_res = neg_q ? -fin_sel : fin_sel;
    end else if (op_q[1:0] == 2'b00) begin
      fin_sel = step_acc[31:0];
      fin_res = fin_sel;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    mplr_d  = mplr_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = op;
          cnt_d = 6'd0;
          if (div0) begin
            res_d   = op[1] ? a : 32'hFFFF_FFFF;
            state_d = DONE;
          end else if (ovf) begin
            res_d   = op[1] ? 32'd0 : 32'h8000_0000;
            state_d = DONE;
          end else begin
            state_d = BUSY;
            if (op[2]) begin
              acc_d  = {32'd0, a_mag};
              opnd_d = {32'd0, b_mag};
              neg_d  = d_sgn && (op[1] ? a[31] : (a[31] ^ b[31]));
            end else begin
              acc_d  = 64'd0;
              opnd_d = (op[1:0] != 2'b11) ? {{32{a[31]}}, a} : {32'd0, a};
              mplr_d = b;
              neg_d  = !op[1];
            end
          end
        end
      end
      BUSY: begin
        acc_d  = step_acc;
        opnd_d = op_q[2] ? opnd_q : {opnd_q[62:0], 1'b0};
        mplr_d = {1'b0, mplr_q[31:1]};
        cnt_d  = cnt_q + 6'd1;
        if (last) begin
          res_d   = fin_res;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (kill) begin
      state_d = IDLE;
      cnt_d   = 6'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 3'd0;
      neg_q   <= 1'b0;
      acc_q   <= 64'd0;
      opnd_q  <= 64'd0;
      mplr_q  <= 32'd0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      mplr_q  <= mplr_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = (state_q == DONE) ? res_q : 32'd0;
  assign zf        = (result == 32'd0);
  assign nf        = result[31];

endmodule

// File: tb/tb_ysyx_23060278_mdu.sv
// Directed and randomised bench for the RV32M multiply/divide unit; expected
// results are queued at acceptance and popped when out_valid appears.
module tb_ysyx_23060278_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zf;
  logic        nf;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  ysyx_23060278_mdu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zf(zf), .nf(nf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, zx, zy, p;
    logic signed [31:0] q;
    logic ov;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    zx = {32'd0, x};
    zy = {32'd0, y};
    ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    q  = 32'sd0;
    p  = 64'sd0;
    case (o)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * zy; return p[63:32]; end
      3'd3: begin p = zx * zy; return p[63:32]; end
      3'd4: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (ov) return 32'h8000_0000;
        q = $signed(x) / $signed(y);
        return q;
      end
      3'd5: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 32'd0) return x;
        if (ov) return 32'd0;
        q = $signed(x) % $signed(y);
        return q;
      end
      default: return (y == 32'd0) ? x : x % y;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int lat, input int hold, input string tag);
    int edges;
    logic [31:0] want, held;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(exp);
    #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk({tag, "_latency"}, 32'(edges), 32'(lat));
    want = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    chk({tag, "_result"}, result, want);
    chk({tag, "_zf"}, {31'd0, zf}, {31'd0, (want == 32'd0)});
    chk({tag, "_nf"}, {31'd0, nf}, {31'd0, want[31]});
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = ~a; op = ~op;
      @(posedge clk);
      #1;
      chk({tag, "_hold_result"}, result, held);
      chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_hold_out_valid"}, {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = (hold > 0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk({tag, "_ret_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_ret_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ret_result"}, result, 32'd0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    int          rl, seen;

    // Reset state
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zf", {31'd0, zf}, 32'd1);
    #10 rst_n = 1'b1;

    // Multiply
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0, "mul");
    run_op(3'd3, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 33, 0, "mulhu");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0, "mulh");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 0, "mulhsu");

    // Divide
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, "rem");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 33, 0, "remu");
    run_op(3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, 0, "divu_by0");
    run_op(3'd6, 32'h1234, 32'd0, 32'h1234, 1, 0, "rem_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, "rem_ovf");

    // Backpressure in DONE with a changing in_valid request
    run_op(3'd0, 32'd9, 32'd11, 32'd99, 33, 5, "bp");

    // Kill at BUSY edge 10
    @(negedge clk);
    op = 3'd0; a = 32'd6; b = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    chk("kill_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("kill_no_out_valid", 32'(seen), 32'd0);

    // Kill in IDLE blocks acceptance
    @(negedge clk);
    in_valid = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; kill = 1'b0;
    chk("idle_kill_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("idle_kill_no_out_valid", 32'(seen), 32'd0);

    // Asynchronous reset mid-BUSY
    @(negedge clk);
    op = 3'd4; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_result", result, 32'd0);
    #4;
    rst_n = 1'b1;
    run_op(3'd0, 32'd3, 32'd5, 32'd15, 33, 0, "mul_after_rst");

    // Randomised operations against the reference model
    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = (i == 3) ? 32'd0 : $urandom;
      rl = (ro[2] && ((ry == 32'd0) ||
            (!ro[0] && rx == 32'h8000_0000 && ry == 32'hFFFF_FFFF))) ? 1 : 33;
      run_op(ro, rx, ry, model(ro, rx, ry), rl, 0, "rnd");
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
